system_nios2_qsys_0_mulx_seq: RTL and testbench
===============================================

// Module: system_nios2_qsys_0_mulx_seq
// PURPOSE
//  Iterative 32x32 multiply sequencer for the Nios II multiply path.
//  Splits each operand pair into four 16x16 unsigned partial products and pushes them through one registered
//  16x16 multiplier. Accumulates the 64-bit product, applies signed correction, and returns the low or high word.
//  Sits beside the low-word mult cell and adds the high-word ops (mulxss/mulxsu/mulxuu) to the A stage.
// PARAMETERS
//  HALF_W  16  partial-product operand width; data width DATA_W = 2*HALF_W, accumulator 4*HALF_W
// PORTS
//  clk            in   1       single clock, rising edge
//  reset          in   1       synchronous reset, active-high
//  A_mul_src1     in   DATA_W  operand a
//  A_mul_src2     in   DATA_W  operand b
//  A_mul_op       in   2       00 mul (low word), 01 mulxss, 10 mulxsu (a signed, b unsigned), 11 mulxuu
//  A_mul_start    in   1       request; accepted only when A_mul_busy=0
//  A_mul_kill     in   1       abort in-flight op (pipeline flush)
//  A_mul_busy     out  1       op in flight (state != IDLE)
//  A_mul_done     out  1       one-cycle pulse, A_mul_result valid
//  A_mul_result   out  DATA_W  selected product word, held until next done
// BEHAVIOUR
//  - Reset (sync, clk edge with reset=1): state=IDLE, busy=0, done=0, result=0, accumulator=0.
//    Reset takes priority over start and kill.
//  - Accept: start=1 and busy=0 in cycle N. At that edge src1, src2 and op are latched.
//    Later input changes have no effect. start while busy=1 is ignored (no queueing).
//  - States: IDLE -> MUL0 -> MUL1 -> MUL2 -> MUL3 -> DRAIN -> FIX -> IDLE.
//    * MULk (cycles N+1..N+4) issue aL*bL, aH*bL, aL*bH, aH*bH to the registered multiplier.
//    * The multiplier has 1-cycle latency. Product k is added at the next edge: P0<<0, P1<<16, P2<<16, P3<<32.
//    * The last add completes in DRAIN (N+5).
//  - FIX (N+6) performs the correction and output select:
//    * Unsigned 64-bit sum S. hi = S[63:32].
//    * mulxss: hi -= (a<0 ? b : 0) + (b<0 ? a : 0).
//    * mulxsu: hi -= (a<0 ? b : 0).
//    * mulxuu: no correction.
//    * All arithmetic is mod 2^DATA_W.
//    * result <= (op==00) ? S[31:0] : hi. done <= 1 at the edge leaving FIX.
//  - Latency: done=1 in cycle N+7, which is also the first IDLE cycle. busy=0 in that cycle.
//    A start in the done cycle is accepted (back-to-back, 7-cycle throughput).
//  - done is high exactly one cycle. result holds its value until the next done or reset.
//  - kill=1 while busy=1: next state IDLE, no done, result unchanged, accumulator cleared on next accept.
//    kill while IDLE has no effect. kill and start in the same IDLE cycle: start accepted, kill ignored.
//  - Accumulator is 4*HALF_W bits, so no overflow. Carries out of bit 63 cannot occur for unsigned operands.
// CONFIGURATION
//  MUL_FAST_LO_EN defined:
//    * op==00 skips MUL3 (aH*bH lies entirely above bit 31).
//    * Sequence IDLE->MUL0->MUL1->MUL2->DRAIN->FIX. done in cycle N+6.
//    * mulx ops unchanged (N+7).
//  MUL_FAST_LO_EN undefined: every op takes the full sequence, done in cycle N+7.
// TESTING
//  1. mul 0x00000003 * 0x00000005, start at N -> done=1 and result=0x0000000F at N+7 (N+6 with MUL_FAST_LO_EN).
//  2. mulxuu 0xFFFFFFFF * 0xFFFFFFFF -> result=0xFFFFFFFE. mul on same operands -> 0x00000001.
//  3. Signed high words:
//     - mulxss 0x80000000 * 0x80000000 -> 0x40000000.
//     - mulxss 0xFFFFFFFF * 0x00000002 -> 0xFFFFFFFF.
//     - mulxsu 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
//  4. start at N, second start plus changed operands at N+2 -> second start ignored.
//     Exactly one done at N+7 with first result.
//  5. reset=1 at N+3 -> busy=0, result=0 at N+4, no done.
//     kill at N+3 instead -> busy=0 at N+4, no done, prior result held.
//  6. Back-to-back: second start in the done cycle N+7 -> accepted, second done at N+14, busy low only at N+7.

Source files
------------

// File: rtl/system_nios2_qsys_0_mulx_seq_if.sv
// Request/response bundle for the iterative 32x32 multiply sequencer.
// The master drives operands and control; the slave (sequencer) returns busy/done/result.
interface system_nios2_qsys_0_mulx_seq_if #(
    parameter int HALF_W = 16
);
    localparam int DATA_W = 2 * HALF_W;

    logic [DATA_W-1:0] A_mul_src1;
    logic [DATA_W-1:0] A_mul_src2;
    logic [1:0]        A_mul_op;
    logic              A_mul_start;
    logic              A_mul_kill;
    logic              A_mul_busy;
    logic              A_mul_done;
    logic [DATA_W-1:0] A_mul_result;

    modport master (
        output A_mul_src1,
        output A_mul_src2,
        output A_mul_op,
        output A_mul_start,
        output A_mul_kill,
        input  A_mul_busy,
        input  A_mul_done,
        input  A_mul_result
    );

    modport slave (
        input  A_mul_src1,
        input  A_mul_src2,
        input  A_mul_op,
        input  A_mul_start,
        input  A_mul_kill,
        output A_mul_busy,
        output A_mul_done,
        output A_mul_result
    );
endinterface

// File: rtl/system_nios2_qsys_0_mulx_seq.sv
// Iterative 32x32 multiply: four 16x16 partial products through one registered multiplier.
// Optional MUL_FAST_LO_EN lets low-word mul skip the aH*bH pass.
module system_nios2_qsys_0_mulx_seq #(
    parameter int HALF_W = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    system_nios2_qsys_0_mulx_seq_if.slave mif
);
    localparam int DATA_W = 2 * HALF_W;
    localparam int ACC_W  = 4 * HALF_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MUL0  = 3'd1;
    localparam logic [2:0] S_MUL1  = 3'd2;
    localparam logic [2:0] S_MUL2  = 3'd3;
    localparam logic [2:0] S_MUL3  = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;
    localparam logic [2:0] S_FIX   = 3'd6;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXSS = 2'b01;
    localparam logic [1:0] OP_MULXSU = 2'b10;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       busy;
    logic       accept;
    logic       flush;

    // Latched operands; data path only, so no reset
    logic [DATA_W-1:0] a_p0;
    logic [DATA_W-1:0] b_p0;
    logic [1:0]        op_p0;

    logic [HALF_W-1:0] mul_a_p0;
    logic [HALF_W-1:0] mul_b_p0;
    logic [1:0]        sh_p0;
    logic              vld_p0;

    logic [DATA_W-1:0] prod_p1;
    logic [1:0]        sh_p1;
    logic              vld_p1;

    logic [ACC_W-1:0]  acc_p2;

    logic [DATA_W-1:0] result_q;
    logic              done_q;

    // Place a 2*HALF_W partial product at its weight: 0, HALF_W or 2*HALF_W
    function automatic logic [ACC_W-1:0] align_pp(input logic [DATA_W-1:0] pp,
                                                  input logic [1:0]        sh);
        logic [ACC_W-1:0] ext;
        ext = ACC_W'(pp);
        case (sh)
            2'd1:    align_pp = ext << HALF_W;
            2'd2:    align_pp = ext << DATA_W;
            default: align_pp = ext;
        endcase
    endfunction

    // Signed high-word correction on the unsigned 64-bit sum; wraps mod 2^DATA_W
    function automatic logic [DATA_W-1:0] fix_word(input logic [ACC_W-1:0]  s,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic [1:0]        op);
        logic signed [DATA_W-1:0] a_s;
        logic signed [DATA_W-1:0] b_s;
        logic [DATA_W-1:0]        hi;
        logic [DATA_W-1:0]        corr;
        a_s  = $signed(a);
        b_s  = $signed(b);
        hi   = s[ACC_W-1:DATA_W];
        corr = '0;
        if (op == OP_MULXSS || op == OP_MULXSU) begin
            if (a_s < 0)
                corr = corr + b;
        end
        if (op == OP_MULXSS) begin
            if (b_s < 0)
                corr = corr + a;
        end
        if (op == OP_MUL)
            fix_word = s[DATA_W-1:0];
        else
            fix_word = hi - corr;
    endfunction

    assign busy   = (state != S_IDLE);
    assign accept = !busy && mif.A_mul_start;
    assign flush  = busy && mif.A_mul_kill;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_MUL0;
            S_MUL0:  state_nxt = S_MUL1;
            S_MUL1:  state_nxt = S_MUL2;
`ifdef MUL_FAST_LO_EN
            // aH*bH only contributes above bit 31, so the low word is final without it
            S_MUL2:  state_nxt = (op_p0 == OP_MUL) ? S_DRAIN : S_MUL3;
`else
            S_MUL2:  state_nxt = S_MUL3;
`endif
            S_MUL3:  state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush)
            state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0  <= mif.A_mul_src1;
            b_p0  <= mif.A_mul_src2;
            op_p0 <= mif.A_mul_op;
        end
    end

    // Stage p0: pick the half-word pair for this MUL state
    always_comb begin
        mul_a_p0 = a_p0[HALF_W-1:0];
        mul_b_p0 = b_p0[HALF_W-1:0];
        sh_p0    = 2'd0;
        vld_p0   = 1'b0;
        case (state)
            S_MUL0: begin
                vld_p0 = 1'b1;
            end
            S_MUL1: begin
                mul_a_p0 = a_p0[DATA_W-1:HALF_W];
                sh_p0    = 2'd1;
                vld_p0   = 1'b1;
            end
            S_MUL2: begin
                mul_b_p0 = b_p0[DATA_W-1:HALF_W];
                sh_p0    = 2'd1;
                vld_p0   = 1'b1;
            end
            S_MUL3: begin
                mul_a_p0 = a_p0[DATA_W-1:HALF_W];
                mul_b_p0 = b_p0[DATA_W-1:HALF_W];
                sh_p0    = 2'd2;
                vld_p0   = 1'b1;
            end
            default: begin
                vld_p0 = 1'b0;
            end
        endcase
    end

    // Stage p1: registered 16x16 unsigned multiplier
    always_ff @(posedge clk) begin
        prod_p1 <= DATA_W'(mul_a_p0) * DATA_W'(mul_b_p0);
        sh_p1   <= sh_p0;
    end

    always_ff @(posedge clk) begin
        if (reset || flush)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= vld_p0;
    end

    // Stage p2: accumulate; a new accept starts from zero, which also discards killed work
    always_ff @(posedge clk) begin
        if (reset)
            acc_p2 <= '0;
        else if (accept)
            acc_p2 <= '0;
        else if (vld_p1)
            acc_p2 <= acc_p2 + align_pp(prod_p1, sh_p1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= (state == S_FIX) && !mif.A_mul_kill;
            if (state == S_FIX && !mif.A_mul_kill)
                result_q <= fix_word(acc_p2, a_p0, b_p0, op_p0);
        end
    end

    assign mif.A_mul_busy   = busy;
    assign mif.A_mul_done   = done_q;
    assign mif.A_mul_result = result_q;

endmodule

// File: tb/tb_system_nios2_qsys_0_mulx_seq.sv
// Directed bench for system_nios2_qsys_0_mulx_seq; expected values computed by hand.
module tb_system_nios2_qsys_0_mulx_seq;
`ifdef MUL_FAST_LO_EN
    localparam int LAT_LO = 6;
`else
    localparam int LAT_LO = 7;
`endif
    localparam int LAT_HI = 7;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    system_nios2_qsys_0_mulx_seq_if #(.HALF_W(16)) mif ();

    system_nios2_qsys_0_mulx_seq #(.HALF_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .mif   (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op at the next negedge, then watch every cycle up to the expected done cycle
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input logic kill_too);
        int early_done;
        int busy_gap;
        early_done = 0;
        busy_gap   = 0;
        @(negedge clk);
        mif.A_mul_src1  = a;
        mif.A_mul_src2  = b;
        mif.A_mul_op    = op;
        mif.A_mul_start = 1'b1;
        mif.A_mul_kill  = kill_too;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                mif.A_mul_start = 1'b0;
                mif.A_mul_kill  = 1'b0;
                mif.A_mul_src1  = $urandom;
                mif.A_mul_src2  = $urandom;
                mif.A_mul_op    = 2'($urandom_range(0, 3));
            end
            if (k < lat) begin
                if (mif.A_mul_done) early_done++;
                if (!mif.A_mul_busy) busy_gap++;
            end
        end
        check({tag, "_done"}, 32'(mif.A_mul_done), 32'd1);
        check({tag, "_busy"}, 32'(mif.A_mul_busy), 32'd0);
        check({tag, "_result"}, mif.A_mul_result, exp);
        check({tag, "_timing"}, 32'(early_done + busy_gap), 32'd0);
    endtask

    initial begin
        int ndone;
        int busy_gap;
        checks          = 0;
        failures        = 0;
        reset           = 1'b1;
        mif.A_mul_src1  = '0;
        mif.A_mul_src2  = '0;
        mif.A_mul_op    = 2'b00;
        mif.A_mul_start = 1'b1;
        mif.A_mul_kill  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(mif.A_mul_busy), 32'd0);
        check("rst_done", 32'(mif.A_mul_done), 32'd0);
        check("rst_result", mif.A_mul_result, 32'd0);
        reset           = 1'b0;
        mif.A_mul_start = 1'b0;

        run_op("mul_3x5", 2'b00, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, LAT_LO, 1'b0);
        @(negedge clk);
        check("done_one_cycle", 32'(mif.A_mul_done), 32'd0);
        check("result_hold", mif.A_mul_result, 32'h0000_000F);

        run_op("mulxuu_ff", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_HI, 1'b0);
        run_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, LAT_LO, 1'b0);
        run_op("mulxss_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_HI, 1'b0);
        run_op("mulxss_m1x2", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, LAT_HI, 1'b0);
        run_op("mulxsu_ff", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_HI, 1'b0);
        // kill together with start in IDLE: start wins
        run_op("mulxsu_killstart", 2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFE, LAT_HI, 1'b1);

        // Second start while busy is dropped
        ndone = 0;
        @(negedge clk);
        mif.A_mul_src1  = 32'h0001_0000;
        mif.A_mul_src2  = 32'h0001_0000;
        mif.A_mul_op    = 2'b11;
        mif.A_mul_start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            mif.A_mul_start = (k == 2);
            if (k == 2) begin
                mif.A_mul_src1 = 32'h1234_5678;
                mif.A_mul_src2 = 32'h9ABC_DEF0;
                mif.A_mul_op   = 2'b00;
            end
            if (k < 7 && mif.A_mul_done) ndone++;
        end
        check("ign_done", 32'(mif.A_mul_done), 32'd1);
        check("ign_result", mif.A_mul_result, 32'h0000_0001);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mif.A_mul_done) ndone++;
        end
        check("ign_extra_done", 32'(ndone), 32'd0);

        // Reset mid-operation
        ndone = 0;
        @(negedge clk);
        mif.A_mul_src1  = 32'h0000_0007;
        mif.A_mul_src2  = 32'h0000_0006;
        mif.A_mul_op    = 2'b11;
        mif.A_mul_start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            mif.A_mul_start = 1'b0;
            reset           = (k == 3);
        end
        check("rstmid_busy", 32'(mif.A_mul_busy), 32'd0);
        check("rstmid_result", mif.A_mul_result, 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mif.A_mul_done) ndone++;
        end
        check("rstmid_no_done", 32'(ndone), 32'd0);

        // Kill mid-operation keeps the previous result
        run_op("mul_7x6", 2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, LAT_LO, 1'b0);
        ndone = 0;
        @(negedge clk);
        mif.A_mul_src1  = 32'h0000_0100;
        mif.A_mul_src2  = 32'h0000_0100;
        mif.A_mul_op    = 2'b00;
        mif.A_mul_start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            mif.A_mul_start = 1'b0;
            mif.A_mul_kill  = (k == 3);
        end
        check("kill_busy", 32'(mif.A_mul_busy), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mif.A_mul_done) ndone++;
        end
        check("kill_no_done", 32'(ndone), 32'd0);
        check("kill_result_held", mif.A_mul_result, 32'h0000_002A);

        // Kill while idle does nothing
        mif.A_mul_kill = 1'b1;
        @(negedge clk);
        mif.A_mul_kill = 1'b0;
        check("kill_idle_busy", 32'(mif.A_mul_busy), 32'd0);
        check("kill_idle_result", mif.A_mul_result, 32'h0000_002A);

        // Back-to-back: restart in the done cycle
        run_op("b2b_first", 2'b11, 32'h0000_1234, 32'h0001_0000, 32'h0000_0000, LAT_HI, 1'b0);
        mif.A_mul_src1  = 32'hFFFF_FFFF;
        mif.A_mul_src2  = 32'h0000_0002;
        mif.A_mul_op    = 2'b11;
        mif.A_mul_start = 1'b1;
        ndone    = 0;
        busy_gap = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            mif.A_mul_start = 1'b0;
            if (k < 7) begin
                if (mif.A_mul_done) ndone++;
                if (!mif.A_mul_busy) busy_gap++;
            end
        end
        check("b2b_busy_gap", 32'(busy_gap), 32'd0);
        check("b2b_early_done", 32'(ndone), 32'd0);
        check("b2b_done", 32'(mif.A_mul_done), 32'd1);
        check("b2b_result", mif.A_mul_result, 32'h0000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
